zap_instr_queue: RTL and testbench

ZAP_INSTR_QUEUE -- requirements
Module: zap_instr_queue

---
 rtl/zap_instr_queue_pkg.sv | 17 +
 rtl/zap_instr_queue.sv | 94 +++++++++
 tb/tb_zap_instr_queue.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/zap_instr_queue_pkg.sv
// Shared types for the fetch -> decode instruction queue, reused by fetch and decode.
package zap_instr_queue_pkg;

  localparam int ZAP_IQ_DEPTH = 4;

  // One queued fetch result: 32 + 1 + 32 + 32 + 2 = 99 bits.
  typedef struct packed {
    logic [31:0] instruction;
    logic        abort;
    logic [31:0] pc_plus_8;
    logic [31:0] pc;
    logic [1:0]  taken;
  } zap_iq_entry_t;

  localparam int ZAP_IQ_ENTRY_W = $bits(zap_iq_entry_t);

endpackage

// File: rtl/zap_instr_queue.sv
// Show-ahead instruction queue between fetch and decode. The head entry is always
// presented on o_*, and the data outputs read zero whenever the queue is empty.
module zap_instr_queue
  import zap_instr_queue_pkg::*;
#(
  parameter int DEPTH = ZAP_IQ_DEPTH
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_stall,
  input  logic        i_valid,
  input  logic [31:0] i_instruction,
  input  logic        i_instr_abort,
  input  logic [31:0] i_pc_plus_8_ff,
  input  logic [31:0] i_pc_ff,
  input  logic [1:0]  i_taken,
  output logic        o_valid,
  output logic [31:0] o_instruction,
  output logic        o_instr_abort,
  output logic [31:0] o_pc_plus_8_ff,
  output logic [31:0] o_pc_ff,
  output logic [1:0]  o_taken,
  output logic        o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  // Handshake: write side transfers when i_valid && !o_full; read side transfers
  // when o_valid && !i_stall. o_full depends only on registered count, so fetch
  // sees no combinational path from i_valid or i_stall.

  zap_iq_entry_t mem [DEPTH];
  zap_iq_entry_t wr_entry;
  zap_iq_entry_t head;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  assign o_valid = (count != '0);
  assign o_full  = (count == FULL_COUNT);
  assign o_count = count;
  assign push    = i_valid && !o_full;
  assign pop     = o_valid && !i_stall;

  assign wr_entry = '{
    instruction: i_instruction,
    abort:       i_instr_abort,
    pc_plus_8:   i_pc_plus_8_ff,
    pc:          i_pc_ff,
    taken:       i_taken
  };

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (i_clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; stale contents are masked by o_valid below.
  always_ff @(posedge i_clk) begin
    if (push && !i_clear) mem[wr_ptr] <= wr_entry;
  end

  always_comb begin
    head = '0;
    if (o_valid) head = mem[rd_ptr];
  end

  assign o_instruction  = head.instruction;
  assign o_instr_abort  = head.abort;
  assign o_pc_plus_8_ff = head.pc_plus_8;
  assign o_pc_ff        = head.pc;
  assign o_taken        = head.taken;

endmodule

// File: tb/tb_zap_instr_queue.sv
// Self-checking bench for zap_instr_queue: directed scenarios plus a randomized
// phase, all compared against a queue-based reference model.
module tb_zap_instr_queue;

  localparam int DEPTH = 4;
  localparam int EW    = 99;

  logic        i_clk;
  logic        i_reset;
  logic        i_clear;
  logic        i_stall;
  logic        i_valid;
  logic [31:0] i_instruction;
  logic        i_instr_abort;
  logic [31:0] i_pc_plus_8_ff;
  logic [31:0] i_pc_ff;
  logic [1:0]  i_taken;
  logic        o_valid;
  logic [31:0] o_instruction;
  logic        o_instr_abort;
  logic [31:0] o_pc_plus_8_ff;
  logic [31:0] o_pc_ff;
  logic [1:0]  o_taken;
  logic        o_full;
  logic [2:0]  o_count;

  logic [EW-1:0] exp_q[$];
  int total_checks = 0;
  int fail_checks  = 0;

  zap_instr_queue #(.DEPTH(DEPTH)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_clear        (i_clear),
    .i_stall        (i_stall),
    .i_valid        (i_valid),
    .i_instruction  (i_instruction),
    .i_instr_abort  (i_instr_abort),
    .i_pc_plus_8_ff (i_pc_plus_8_ff),
    .i_pc_ff        (i_pc_ff),
    .i_taken        (i_taken),
    .o_valid        (o_valid),
    .o_instruction  (o_instruction),
    .o_instr_abort  (o_instr_abort),
    .o_pc_plus_8_ff (o_pc_plus_8_ff),
    .o_pc_ff        (o_pc_ff),
    .o_taken        (o_taken),
    .o_full         (o_full),
    .o_count        (o_count)
  );

  // Clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [EW-1:0] mk_entry(input logic [31:0] instr, input logic abort,
                                             input logic [31:0] pc, input logic [1:0] taken);
    return {instr, abort, pc + 32'd8, pc, taken};
  endfunction

  function automatic logic [EW-1:0] rand_entry();
    logic [31:0] pc;
    pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    return mk_entry($urandom, 1'($urandom_range(0, 1)), pc, 2'($urandom_range(0, 3)));
  endfunction

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    total_checks++;
    assert (obs === exp) else begin
      fail_checks++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: DUT head and flags versus the model queue.
  task automatic check_outputs(input string tag);
    logic [EW-1:0] head;
    int sz;
    sz   = exp_q.size();
    head = (sz != 0) ? exp_q[0] : '0;
    chk({tag, "_valid"}, EW'(o_valid), EW'(sz != 0));
    chk({tag, "_count"}, EW'(o_count), EW'(sz));
    chk({tag, "_full"},  EW'(o_full),  EW'(sz == DEPTH));
    chk({tag, "_head"},  {o_instruction, o_instr_abort, o_pc_plus_8_ff, o_pc_ff, o_taken}, head);
  endtask

  // Driver: one clock cycle from a negedge to the next; model updated at the edge.
  task automatic cycle(input logic v, input logic [EW-1:0] e, input logic st,
                       input logic clr, input string tag, output logic acc);
    logic pop;
    i_valid = v;
    {i_instruction, i_instr_abort, i_pc_plus_8_ff, i_pc_ff, i_taken} = e;
    i_stall = st;
    i_clear = clr;
    acc = v && (exp_q.size() != DEPTH);
    pop = (exp_q.size() != 0) && !st;
    @(posedge i_clk);
    if (clr) begin
      exp_q.delete();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(e);
    end
    @(negedge i_clk);
    check_outputs(tag);
  endtask

  task automatic idle(input logic st, input string tag);
    logic acc;
    cycle(1'b0, '0, st, 1'b0, tag, acc);
  endtask

  initial begin
    logic [EW-1:0] pend;
    logic acc;
    logic [EW-1:0] items[5];

    i_reset = 1'b1; i_clear = 1'b0; i_stall = 1'b0; i_valid = 1'b0;
    i_instruction = '0; i_instr_abort = 1'b0; i_pc_plus_8_ff = '0; i_pc_ff = '0; i_taken = '0;
    repeat (2) @(negedge i_clk);
    check_outputs("reset");
    i_reset = 1'b0;
    @(negedge i_clk);
    check_outputs("post_reset");

    // Single push, visible one cycle later, popped at the next edge
    cycle(1'b1, mk_entry(32'hE1A00000, 1'b0, 32'h100, 2'b00), 1'b0, 1'b0, "single", acc);
    chk("single_instr", EW'(o_instruction), EW'(32'hE1A00000));
    chk("single_pc", EW'(o_pc_ff), EW'(32'h100));
    chk("single_pc8", EW'(o_pc_plus_8_ff), EW'(32'h108));
    idle(1'b0, "single_pop");

    // Fill while stalled; fifth held by fetch until space appears
    for (int i = 0; i < 5; i++) items[i] = rand_entry();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, items[i], 1'b1, 1'b0, "fill", acc);
      chk("fill_acc", EW'(acc), EW'(i < 4));
    end
    chk("fill_full", EW'(o_full), EW'(1));
    chk("fill_count", EW'(o_count), EW'(4));
    pend = items[4];
    acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) cycle(1'b1, pend, 1'b0, 1'b0, "release", acc);
    chk("release_taken", EW'(acc), EW'(1));
    repeat (5) idle(1'b0, "drain");

    // Full queue, streaming with no stall across pointer wrap
    for (int i = 0; i < 4; i++) cycle(1'b1, rand_entry(), 1'b1, 1'b0, "prefill", acc);
    pend = rand_entry();
    for (int i = 0; i < 14; i++) begin
      cycle(1'b1, pend, 1'b0, 1'b0, "stream", acc);
      if (acc) pend = rand_entry();
    end
    repeat (5) idle(1'b0, "stream_drain");

    // Clear beats a concurrent push
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_entry(), 1'b1, 1'b0, "pre_clear", acc);
    cycle(1'b1, rand_entry(), 1'b0, 1'b1, "clear", acc);
    chk("clear_valid", EW'(o_valid), EW'(0));
    chk("clear_count", EW'(o_count), EW'(0));

    // Abort entries pass through in order
    cycle(1'b1, rand_entry(), 1'b1, 1'b0, "abort_a", acc);
    cycle(1'b1, mk_entry(32'hDEADBEEF, 1'b1, 32'h200, 2'b10), 1'b1, 1'b0, "abort_b", acc);
    cycle(1'b1, rand_entry(), 1'b1, 1'b0, "abort_c", acc);
    idle(1'b0, "abort_pop1");
    chk("abort_flag", EW'(o_instr_abort), EW'(1));
    chk("abort_taken", EW'(o_taken), EW'(2'b10));
    repeat (3) idle(1'b0, "abort_drain");

    // Randomized traffic with a fetch-holding upstream
    pend = rand_entry();
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 9) < 7), pend, 1'($urandom_range(0, 9) < 3),
            1'($urandom_range(0, 99) < 3), "rand", acc);
      if (acc) pend = rand_entry();
    end

    // Asynchronous reset mid-cycle with two entries held
    i_clear = 1'b0;
    cycle(1'b1, rand_entry(), 1'b1, 1'b0, "pre_rst", acc);
    cycle(1'b1, rand_entry(), 1'b1, 1'b0, "pre_rst", acc);
    while (exp_q.size() < 2) cycle(1'b1, rand_entry(), 1'b1, 1'b0, "pre_rst", acc);
    i_valid = 1'b0;
    #2;
    i_reset = 1'b1;
    exp_q.delete();
    #1;
    check_outputs("async_rst");
    @(negedge i_clk);
    check_outputs("rst_hold");
    i_reset = 1'b0;
    cycle(1'b1, mk_entry(32'h12345678, 1'b0, 32'h400, 2'b01), 1'b0, 1'b0, "after_rst", acc);
    chk("after_rst_instr", EW'(o_instruction), EW'(32'h12345678));
    idle(1'b0, "after_rst_pop");

    $display("%0d/%0d checks passed", total_checks - fail_checks, total_checks);
    $finish;
  end

endmodule
